// File: rtl/mlp_top.sv
// mlp_top: two-layer fixed-point MLP with LUT activation, shared write bus; define OUTPUT_ACT_EN to also activate outputs
module mlp_top #(
  parameter int N_IN = 784,
  parameter int N_HID = 200,
  parameter int WE_W = 794,
  parameter int LUT_DEPTH = 121,
  parameter int FRAC = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              en,
  input  logic [WE_W-1:0]         we,
  input  logic                    active_we,
  input  logic signed [15:0]      wdata,
  input  logic [17:0]             addr,
  output logic signed [15:0]      output0,
  output logic signed [15:0]      output1,
  output logic signed [15:0]      output2,
  output logic signed [15:0]      output3,
  output logic signed [15:0]      output4,
  output logic signed [15:0]      output5,
  output logic signed [15:0]      output6,
  output logic signed [15:0]      output7,
  output logic signed [15:0]      output8,
  output logic signed [15:0]      output9
);
  localparam int IW = N_IN > 1 ? $clog2(N_IN) : 1;
  localparam int HW = N_HID > 1 ? $clog2(N_HID) : 1;
  localparam int CW = IW > HW ? IW : HW;
  localparam int LW = LUT_DEPTH > 1 ? $clog2(LUT_DEPTH) : 1;
  localparam int PW = $clog2(LUT_DEPTH + 1);
  localparam logic [CW-1:0] I_LAST = CW'(N_IN - 1);
  localparam logic [CW-1:0] HI_LAST = CW'(N_HID - 1);
  localparam logic [HW-1:0] H_LAST = HW'(N_HID - 1);
  typedef enum logic [2:0] {IDLE, L1_MAC, L1_ACT, L2_MAC, L2_ACT, DONE} state_t;
  state_t state;
  logic signed [15:0] w1 [N_HID][N_IN];
  logic signed [15:0] w2 [10][N_HID];
  logic signed [15:0] x [N_IN];
  logic signed [15:0] h [N_HID];
  logic signed [15:0] y [10];
  logic signed [15:0] lut_key [LUT_DEPTH];
  logic signed [15:0] lut_val [LUT_DEPTH];
  logic [CW-1:0] i;
  logic [HW-1:0] j;
  logic [3:0] k;
  logic [PW-1:0] ptr;
  logic signed [47:0] acc, sh;
  logic signed [31:0] prod;
  logic signed [15:0] a_op, b_op, s, act_s, y_in;
  logic idle, in_x, in_h, wr_w1, wr_w2, wr_x, wr_lut, start, unused_we;
  assign idle = state == IDLE;
  assign in_x = addr < 18'(N_IN);
  assign in_h = addr < 18'(N_HID);
  assign wr_w1 = idle && en == 2'b01 && in_x;
  assign wr_w2 = idle && en == 2'b10 && in_h;
  assign wr_x = idle && en == 2'b11 && active_we && in_x;
  assign wr_lut = idle && en == 2'b00 && active_we && ptr < PW'(LUT_DEPTH);
  assign start = wr_x && addr == 18'(N_IN - 1);
  assign unused_we = ^we;
  assign a_op = state == L1_MAC ? x[i[IW-1:0]] : h[i[HW-1:0]];
  assign b_op = state == L1_MAC ? w1[j][i[IW-1:0]] : w2[k][i[HW-1:0]];
  assign prod = 32'(a_op) * 32'(b_op);
  assign sh = acc >>> FRAC;
  assign s = sh > 48'sd32767 ? 16'sh7FFF : sh < -48'sd32768 ? 16'sh8000 : sh[15:0];
  // breakpoint activation: last loaded key not above s wins, entry 0 below all keys, identity when empty
  always_comb begin
    act_s = ptr == '0 ? s : lut_val[0];
    for (int e = 0; e < LUT_DEPTH; e++)
      if (PW'(e) < ptr && lut_key[e] <= s) act_s = lut_val[e];
  end
`ifdef OUTPUT_ACT_EN
  assign y_in = act_s;
`else
  assign y_in = s;
`endif
  // sequencer: MAC over fan-in, one activation cycle per neuron, outputs published together in DONE
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      i <= '0;
      j <= '0;
      k <= '0;
      acc <= '0;
      ptr <= '0;
      {output9, output8, output7, output6, output5, output4, output3, output2, output1, output0} <= '0;
    end else begin
      if (wr_lut) ptr <= ptr + PW'(1);
      case (state)
        IDLE: if (start) begin
          state <= L1_MAC;
          i <= '0;
          j <= '0;
          acc <= '0;
        end
        L1_MAC: begin
          acc <= acc + 48'(prod);
          i <= i + CW'(1);
          if (i == I_LAST) state <= L1_ACT;
        end
        L1_ACT: begin
          acc <= '0;
          i <= '0;
          j <= j == H_LAST ? '0 : j + HW'(1);
          k <= '0;
          state <= j == H_LAST ? L2_MAC : L1_MAC;
        end
        L2_MAC: begin
          acc <= acc + 48'(prod);
          i <= i + CW'(1);
          if (i == HI_LAST) state <= L2_ACT;
        end
        L2_ACT: begin
          acc <= '0;
          i <= '0;
          k <= k == 4'd9 ? k : k + 4'd1;
          state <= k == 4'd9 ? DONE : L2_MAC;
        end
        DONE: begin
          {output9, output8, output7, output6, output5, output4, output3, output2, output1, output0} <=
            {y[9], y[8], y[7], y[6], y[5], y[4], y[3], y[2], y[1], y[0]};
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  // storage: bus writes while idle, hidden and output results captured in the activation cycles
  always_ff @(posedge clk) begin
    for (int n = 0; n < N_HID; n++) if (wr_w1 && we[n]) w1[n][addr[IW-1:0]] <= wdata;
    for (int n = 0; n < 10; n++) if (wr_w2 && we[n]) w2[n][addr[HW-1:0]] <= wdata;
    if (wr_x) x[addr[IW-1:0]] <= wdata;
    if (wr_lut) lut_key[ptr[LW-1:0]] <= addr[15:0];
    if (wr_lut) lut_val[ptr[LW-1:0]] <= wdata;
    if (state == L1_ACT) h[j] <= act_s;
    if (state == L2_ACT) y[k] <= y_in;
  end
endmodule

// File: tb/tb_mlp_top.sv
// tb_mlp_top: scoreboard bench for mlp_top with a small network (4 inputs, 2 hidden, 2 LUT entries)
module tb_mlp_top;
  localparam int N_IN = 4;
  localparam int N_HID = 2;
  localparam int WE_W = 10;
  localparam int LD = 2;
  localparam int LAT = N_HID * (N_IN + 1) + 10 * (N_HID + 1) + 1;
  logic clk, reset, active_we;
  logic [1:0] en;
  logic [WE_W-1:0] we;
  logic signed [15:0] wdata;
  logic [17:0] addr;
  logic signed [15:0] o0, o1, o2, o3, o4, o5, o6, o7, o8, o9;
  logic [159:0] obs, last_exp;
  logic [159:0] exp_q[$];
  logic signed [15:0] mx [N_IN];
  logic signed [15:0] mw1 [N_HID][N_IN];
  logic signed [15:0] mw2 [10][N_HID];
  logic signed [15:0] lk [LD];
  logic signed [15:0] lv [LD];
  int lptr = 0;
  int cyc = 0;
  int ntests = 0;
  int nfail = 0;
  assign obs = {o9, o8, o7, o6, o5, o4, o3, o2, o1, o0};
  mlp_top #(.N_IN(N_IN), .N_HID(N_HID), .WE_W(WE_W), .LUT_DEPTH(LD), .FRAC(8)) dut (
    .clk(clk), .reset(reset), .en(en), .we(we), .active_we(active_we), .wdata(wdata), .addr(addr),
    .output0(o0), .output1(o1), .output2(o2), .output3(o3), .output4(o4),
    .output5(o5), .output6(o6), .output7(o7), .output8(o8), .output9(o9)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic signed [15:0] sat_m(input logic signed [47:0] a);
    logic signed [47:0] t;
    t = a >>> 8;
    if (t > 32767) return 16'sh7FFF;
    if (t < -32768) return 16'sh8000;
    return t[15:0];
  endfunction

  function automatic logic signed [15:0] act_m(input logic signed [15:0] v);
    if (lptr == 0) return v;
    for (int e = lptr - 1; e >= 0; e--) if (lk[e] <= v) return lv[e];
    return lv[0];
  endfunction

  function automatic logic [159:0] model();
    logic signed [47:0] acc;
    logic signed [15:0] hh [N_HID];
    logic signed [15:0] yv;
    logic [159:0] r;
    r = '0;
    for (int j = 0; j < N_HID; j++) begin
      acc = 0;
      for (int i = 0; i < N_IN; i++) acc += mx[i] * mw1[j][i];
      hh[j] = act_m(sat_m(acc));
    end
    for (int k = 0; k < 10; k++) begin
      acc = 0;
      for (int i = 0; i < N_HID; i++) acc += hh[i] * mw2[k][i];
      yv = sat_m(acc);
`ifdef OUTPUT_ACT_EN
      yv = act_m(yv);
`endif
      r[k*16 +: 16] = yv;
    end
    return r;
  endfunction

  task automatic wr(input logic [1:0] e, input logic [WE_W-1:0] w, input logic aw, input logic [17:0] a, input logic [15:0] d);
    @(negedge clk);
    en = e; we = w; active_we = aw; addr = a; wdata = d;
    @(posedge clk);
    #1;
    we = '0; active_we = 0;
  endtask

  task automatic px_wr(input int a, input logic [15:0] d);
    wr(2'b11, '0, 1, 18'(a), d);
    if (a < N_IN) mx[a] = d;
  endtask

  task automatic w1_wr(input logic [WE_W-1:0] m, input int a, input logic [15:0] d);
    wr(2'b01, m, 0, 18'(a), d);
    for (int j = 0; j < N_HID; j++) if (m[j] && a < N_IN) mw1[j][a] = d;
  endtask

  task automatic w2_wr(input logic [WE_W-1:0] m, input int a, input logic [15:0] d);
    wr(2'b10, m, 0, 18'(a), d);
    for (int k = 0; k < 10; k++) if (m[k] && a < N_HID) mw2[k][a] = d;
  endtask

  task automatic lut_wr(input logic [15:0] key, input logic [15:0] val);
    wr(2'b00, '0, 1, {2'b00, key}, val);
    if (lptr < LD) begin
      lk[lptr] = key; lv[lptr] = val; lptr++;
    end
  endtask

  task automatic do_reset();
    #2 reset = 0;
    #2;
    @(negedge clk) reset = 1;
    lptr = 0;
    last_exp = '0;
  endtask

  task automatic run(input string name, input logic [15:0] d, input bit gate);
    logic [159:0] e;
    int c0;
    mx[N_IN-1] = d;
    exp_q.push_back(model());
    wr(2'b11, '0, 1, 18'(N_IN - 1), d);
    c0 = cyc;
    if (gate) begin
      wr(2'b01, 10'h003, 0, 18'd0, 16'h1234);
      wr(2'b10, 10'h3FF, 0, 18'd1, 16'h4321);
      wr(2'b11, '0, 1, 18'd0, 16'h0777);
      wr(2'b11, '0, 1, 18'(N_IN - 1), 16'h0555);
    end
    while (cyc < c0 + LAT - 1) begin
      @(posedge clk);
      #1;
    end
    ntests++;
    if (obs !== last_exp) begin
      nfail++;
      $display("FAIL %s_hold: outputs %h before latency, required %h", name, obs, last_exp);
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    ntests++;
    if (obs !== e) begin
      nfail++;
      $display("FAIL %s: outputs %h, required %h", name, obs, e);
    end
    last_exp = e;
  endtask

  task automatic test_reset();
    reset = 1;
    #2 reset = 0;
    #1;
    ntests++;
    if (obs !== 160'h0) begin
      nfail++;
      $display("FAIL reset_outputs: outputs %h, required 0", obs);
    end
    @(negedge clk) reset = 1;
    lptr = 0;
    last_exp = '0;
  endtask

  task automatic test_identity();
    for (int i = 0; i < N_IN - 1; i++) px_wr(i, 16'h0100);
    for (int i = 0; i < N_IN; i++) begin
      w1_wr(10'h001, i, 16'h0100);
      w1_wr(10'h002, i, 16'h0080);
    end
    for (int i = 0; i < N_HID; i++) begin
      w2_wr(10'h001, i, 16'h0100);
      w2_wr(10'h3FE, i, 16'h0000);
    end
    run("identity", 16'h0100, 0);
    ntests++;
    if (obs !== {144'h0, 16'h0600}) begin
      nfail++;
      $display("FAIL identity_const: outputs %h, required output0=0600 rest 0", obs);
    end
  endtask

  task automatic test_lut_relu();
    logic [15:0] e1, e2;
    do_reset();
    lut_wr(16'h8000, 16'h0000);
    lut_wr(16'h0000, 16'h0100);
    lut_wr(16'h0100, 16'h7777);
    for (int i = 0; i < N_IN; i++) begin
      w1_wr(10'h001, i, 16'hFF00);
      w1_wr(10'h002, i, 16'h0080);
    end
    w2_wr(10'h001, 0, 16'h0100); w2_wr(10'h001, 1, 16'h0100);
    w2_wr(10'h002, 0, 16'h0100); w2_wr(10'h002, 1, 16'h0000);
    w2_wr(10'h004, 0, 16'h0000); w2_wr(10'h004, 1, 16'hFF00);
    run("lut_relu", 16'h0100, 0);
`ifdef OUTPUT_ACT_EN
    e1 = 16'h0100; e2 = 16'h0000;
`else
    e1 = 16'h0000; e2 = 16'hFF00;
`endif
    ntests++;
    if (o0 !== 16'h0100 || o1 !== e1 || o2 !== e2) begin
      nfail++;
      $display("FAIL lut_const: out0..2 %h %h %h, required 0100 %h %h", o0, o1, o2, e1, e2);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < N_IN - 1; i++) px_wr(i, 16'h7FFF);
    for (int i = 0; i < N_IN; i++) begin
      w1_wr(10'h001, i, 16'h7FFF);
      w1_wr(10'h002, i, 16'h8000);
    end
    w2_wr(10'h001, 0, 16'h7FFF); w2_wr(10'h001, 1, 16'h0000);
    w2_wr(10'h002, 0, 16'h0000); w2_wr(10'h002, 1, 16'h7FFF);
    w2_wr(10'h004, 0, 16'h0100); w2_wr(10'h004, 1, 16'h0100);
    run("saturation", 16'h7FFF, 0);
    ntests++;
    if (o0 !== 16'h7FFF || o1 !== 16'h8000) begin
      nfail++;
      $display("FAIL sat_const: out0 %h out1 %h, required 7fff 8000", o0, o1);
    end
  endtask

  task automatic test_write_gating();
    for (int i = 0; i < N_IN - 1; i++) px_wr(i, 16'h0100);
    for (int i = 0; i < N_IN; i++) begin
      w1_wr(10'h001, i, 16'h0100);
      w1_wr(10'h002, i, 16'h0080);
    end
    w2_wr(10'h001, 0, 16'h0100); w2_wr(10'h001, 1, 16'h0100);
    w2_wr(10'h002, 0, 16'h0100); w2_wr(10'h002, 1, 16'h0000);
    w2_wr(10'h004, 0, 16'h0000); w2_wr(10'h004, 1, 16'h0100);
    run("gated", 16'h0100, 1);
    for (int i = 0; i < N_IN; i++) w1_wr(10'h003, i, 16'h0040);
    w1_wr(10'h001, N_IN, 16'h7000);
    w2_wr(10'h001, N_HID, 16'h7000);
    px_wr(N_IN, 16'h7000);
    run("multi_hot", 16'h0100, 0);
    ntests++;
    if (o0 !== 16'h0200 || o1 !== 16'h0100) begin
      nfail++;
      $display("FAIL multi_hot_const: out0 %h out1 %h, required 0200 0100", o0, o1);
    end
  endtask

  task automatic test_reset_mid();
    mx[N_IN-1] = 16'h0200;
    wr(2'b11, '0, 1, 18'(N_IN - 1), 16'h0200);
    repeat (10) @(posedge clk);
    #3 reset = 0;
    #1;
    ntests++;
    if (obs !== 160'h0) begin
      nfail++;
      $display("FAIL reset_mid: outputs %h, required 0", obs);
    end
    @(negedge clk) reset = 1;
    lptr = 0;
    last_exp = '0;
    run("after_reset", 16'h0100, 0);
  endtask

  task automatic test_back_to_back();
    run("b2b_a", 16'h0200, 0);
    run("b2b_b", 16'hFF80, 0);
  endtask

  initial begin
    reset = 1; en = 0; we = '0; active_we = 0; wdata = 0; addr = 0; last_exp = '0;
    test_reset();
    test_identity();
    test_lut_relu();
    test_saturation();
    test_write_gating();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/mlp_top.md
Name: mlp_top

Overview:
- Two-layer fixed-point MLP inference engine: N_IN inputs, N_HID hidden neurons, 10 outputs.
- Contains on-chip storage for layer-1 weights, layer-2 weights, input pixels and a breakpoint activation look-up table (LUT).
- All storage is loaded through one shared write bus. Inference starts automatically when the last input pixel is written.
- Results appear on ten parallel 16-bit outputs. This is the top level of the accelerator.

Parameters:
- N_IN, 784, number of input pixels / layer-1 fan-in.
- N_HID, 200, number of hidden neurons / layer-2 fan-in.
- WE_W, 794, width of the we select bus; must be at least N_HID.
- LUT_DEPTH, 121, number of activation LUT entries.
- FRAC, 8, fractional bits of the signed Q-format (Q7.8 with FRAC=8).

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous active-low reset.
- en, input, 2, write target: 00 LUT, 01 layer-1 weights, 10 layer-2 weights, 11 input pixels.
- we, input, WE_W, one-hot (multi-hot allowed) neuron select for weight writes.
- active_we, input, 1, LUT write strobe (used when en=00) and input-pixel strobe (used when en=11).
- wdata, input, 16, signed write data.
- addr, input, 18, fan-in index for weights, pixel index for inputs, LUT key for LUT writes.
- output0..output9, output, 16 each, signed class scores.

Behaviour:
- One clock domain; reset is asynchronous and active-low.
- Reset state:
  - output0..9 = 0.
  - FSM in IDLE.
  - LUT write pointer = 0.
  - Weight, pixel and LUT memories are not cleared.
- Writes are accepted only in IDLE, on the rising clk edge.
  - en=01: for every j<N_HID with we[j]=1, W1[j][addr]=wdata.
  - en=10: for every k<10 with we[k]=1, W2[k][addr]=wdata.
  - en=11 and active_we=1: X[addr]=wdata.
  - en=00 and active_we=1: LUT[ptr] = {key=addr[15:0], val=wdata}; ptr increments and saturates at LUT_DEPTH. Extra writes are ignored.
- Out-of-range addr (at or above the fan-in) is ignored. Writes outside IDLE are ignored.
- Start: the cycle after a pixel write with addr=N_IN-1, FSM leaves IDLE.
- FSM: IDLE -> L1_MAC -> L1_ACT -> (next j, or L2_MAC) -> L2_ACT -> (next k, or DONE) -> IDLE.
  - L1_MAC: 1 MAC per cycle, acc += X[i]*W1[j][i], i = 0..N_IN-1. Products are 32-bit; the accumulator is 48-bit signed and cleared at the start of each neuron.
  - L1_ACT (1 cycle): s = acc>>>FRAC, saturated to 16-bit signed; H[j] = act(s).
  - L2_MAC: acc += H[i]*W2[k][i], i = 0..N_HID-1.
  - L2_ACT (1 cycle): Y[k] = saturated acc>>>FRAC, with activation applied only per Optional Feature.
  - DONE (1 cycle): output0..9 update simultaneously from Y[0..9]. Outputs hold their old values during compute.
- Latency from start to outputs updating = N_HID*(N_IN+1) + 10*(N_HID+1) + 1 cycles.
- act(x):
  - Returns the val of the highest-index loaded entry whose signed key <= x.
  - If x is below all keys, returns val of entry 0.
  - If ptr=0 (no entries loaded), act(x)=x.
  - Keys must be loaded in ascending order; behaviour is undefined otherwise.
- Reset mid-computation aborts to IDLE and zeroes the outputs. Memories are retained, so a new start requires only rewriting pixel N_IN-1.

Optional Feature:
- Macro OUTPUT_ACT_EN.
- Defined: Y[k] = act(saturated sum) in L2_ACT.
- Undefined: Y[k] = raw saturated sum; the LUT is used for the hidden layer only.
- Latency is identical in both cases.

Test Plan:
- Reset: assert reset=0 mid-run -> all outputs 0 immediately (asynchronous), FSM in IDLE, next write accepted.
- Identity path (N_IN=4, N_HID=2, no LUT loaded):
  - Stimulus: X=1.0 (0x0100) in all pixels; W1[0][*]=0x0100, W1[1][*]=0x0080; W2[0]={0x0100,0x0100}, other W2 rows 0.
  - Required response: after 2*5+10*3+1=41 cycles, output0=0x0600 and output1..9=0.
- LUT ReLU:
  - Load keys {0x8000, 0x0000}; these two entries bound the step for negative inputs.
  - Stimulus: a negative hidden sum.
  - Required response: that hidden value maps to the val of entry 0, and output0 reflects it.
- Saturation: sum exceeding +127.996 -> hidden/output value 0x7FFF; a large negative sum -> 0x8000.
- Write gating:
  - A weight write during compute is ignored; outputs match the pre-write weights.
  - A multi-hot we write loads all selected neurons with the same value.
- OUTPUT_ACT_EN: same stimulus with and without the macro -> outputs differ exactly by the LUT mapping.
